mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller that shares the single 8-bit RAM port between instruction fetch (IF) and the load/store buffer (LSB). It arbitrates between the two requesters and splits each request into byte accesses. It assembles read data and pulses a done/valid back to the served requester. It sits between the IF/LSB units and the top-level RAM/IO bus, and it honours ROB rollback.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, requester data width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable. When low, all state is frozen and no RAM write is issued.
- rollback_from_rob  in  1  flush pulse
- if_valid  in  1  IF word-fetch request. Held until if_done.
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse: if_data is valid
- if_data  out  32  fetched word, little-endian
- lsb_valid  in  1  LSB request. Held until lsb_done.
- lsb_wr  in  1  1 = store, 0 = load
- lsb_size  in  2  00 = byte, 01 = half, 10 = word
- lsb_signed  in  1  sign-extend a load result
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data; low bytes are used
- lsb_done  out  1  one-cycle pulse: store finished, or lsb_rdata valid
- lsb_rdata  out  32  load result, extended to 32 bits
- mem_din  in  8  RAM read data
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full

## Operation
- States: IDLE, READ, WRITE.
  - IDLE → READ on a granted IF fetch or LSB load.
  - IDLE → WRITE on a granted LSB store.
  - READ/WRITE → IDLE after the last byte.
- Byte count N: IF = 4; LSB = 1, 2 or 4 from lsb_size.
- Byte k is at address base+k. The address increments by 1 with no alignment check. ADDR_W wraps modulo 2^32.
- Arbitration happens only in IDLE.
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one not served last. The last-served flag resets to IF, so LSB wins the first tie.
- READ:
  - Byte k is driven on mem_a in cycle A0+k, with mem_wr=0.
  - Byte k is captured from mem_din in cycle A0+k+1 (1-cycle RAM latency).
  - Data is assembled little-endian.
  - An LSB load is extended by lsb_signed: sign-extended from bit 7 or 15, otherwise zero-extended.
- WRITE: byte k of lsb_wdata is driven on mem_dout and mem_a, with mem_wr=1, in cycle A0+k.
- Rollback (sampled at a posedge with rdy=1):
  - An active READ (IF or load) is aborted: return to IDLE, no done pulse, captured data discarded.
  - An active WRITE always completes, because stores are committed.
  - Requests presented in the rollback cycle are not granted.
- Outside an active byte cycle, mem_wr=0, mem_a=0 and mem_dout=0. Both done outputs are 0 except in their pulse cycle.

## Timing
- Grant: request sampled at posedge G in IDLE. The first byte address cycle A0 is G+1.
- Read of N bytes: done pulse and data in cycle A0+N+1.
  - IF word: 6 cycles from G to if_done.
- Write of N bytes: lsb_done pulse in cycle A0+N.
- The done cycle is an IDLE cycle. New requests are sampled at its posedge, so back-to-back A0 is done+1.
- A requester must deassert or change its request in the cycle after its done. A request still held then is a new request.
- Reset values: state IDLE, all outputs 0, if_data and lsb_rdata 0, last-served flag = IF.
- Reset mid-transaction aborts immediately: mem_wr drops asynchronously, no done pulse.
- rdy low: the counter, state and outputs hold. mem_wr is forced to 0 while rdy=0, so no duplicate write occurs. The byte resumes when rdy returns.

## Configuration
- IO_STALL_EN
  - Defined: a WRITE byte whose address has addr[17:16]=2'b11 (IO space) is not issued while io_buffer_full=1. The controller holds the same byte with mem_wr=0 until the buffer is not full. The same check also applies for one cycle after each IO write, because the full flag lags.
  - Undefined: io_buffer_full is ignored, and IO writes issue one byte per cycle like RAM.

## Structure
- Shared header (utils.v): ADDR_RANGE, DATA_RANGE, size encodings (SIZE_B, SIZE_H, SIZE_W), IO address-space macro.
- One natural sub-module: mem_rr_arb. It is the two-requester round-robin grant with the last-served flag, registered on grant.
- Byte assembly and extension are inline.

## Test plan
- IF fetch of 0x00001000, RAM bytes 0x13,0x05,0x10,0x00 → mem_a 0x1000..0x1003 in cycles G+1..G+4; if_done in G+6 with if_data=0x00100513.
- LSB signed half load at 0x2002, bytes 0xFE,0xFF → lsb_rdata=0xFFFFFFFE. The same load unsigned → 0x0000FFFE.
- LSB word store 0xDEADBEEF to 0x3000 → mem_wr=1 for 4 cycles with mem_dout EF,BE,AD,DE; lsb_done in A0+4.
- IF and LSB both valid in IDLE after reset → LSB served first, then IF. The next tie goes to LSB.
- Rollback in cycle A0+1 of an IF fetch → no if_done, IDLE next cycle. Rollback during a store → the store completes with lsb_done.
- With IO_STALL_EN, a byte store to 0x30000 while io_buffer_full=1 for 3 cycles → mem_wr stays 0 for those cycles, then one write; lsb_done follows.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types, size encodings and address-space helpers for mem_ctrl.
package mem_ctrl_pkg;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] IO_SPACE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  // UART and other devices live where addr[17:16] == 2'b11.
  function automatic logic is_io(input logic [ADDR_BITS-1:0] addr);
    return addr[17:16] == IO_SPACE;
  endfunction
endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester round-robin grant (IF vs LSB); the last-served flag updates on grant.
module mem_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_if,
  input  logic i_req_lsb,
  output logic o_gnt_if,
  output logic o_gnt_lsb
);
  logic r_last_lsb;

  // On a tie the requester not served last wins; the flag resets to IF so LSB wins first.
  assign o_gnt_lsb = i_en & i_req_lsb & (~i_req_if | ~r_last_lsb);
  assign o_gnt_if  = i_en & i_req_if & ~o_gnt_lsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_lsb <= 1'b0;
    end else if (o_gnt_if || o_gnt_lsb) begin
      r_last_lsb <= o_gnt_lsb;
    end
  end
endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit RAM port between IF and LSB.
// Optional IO write back-pressure is enabled with `define IO_STALL_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_BITS,
  parameter int DATA_W = DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback_from_rob,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              lsb_valid,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic              lsb_signed,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  // Handshake: a requester holds *_valid until its one-cycle *_done; the done cycle is
  // IDLE, and the requester just served is not re-granted at the end of that cycle.
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_buf, r_if_data, r_lsb_rdata;
  logic [2:0]        r_cnt, r_n;
  logic [1:0]        r_size;
  logic              r_signed, r_is_if, r_if_done, r_lsb_done;

  logic              w_gnt_en, w_gnt_if, w_gnt_lsb;
  logic              w_issue, w_rd_last, w_wr_last, w_stall, w_bus_act;
  logic [DATA_W-1:0] w_asm, w_ext;

  assign w_gnt_en = (r_state == ST_IDLE) & rdy & ~rollback_from_rob;

  mem_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_gnt_en),
    .i_req_if  (if_valid & ~r_if_done),
    .i_req_lsb (lsb_valid & ~r_lsb_done),
    .o_gnt_if  (w_gnt_if),
    .o_gnt_lsb (w_gnt_lsb)
  );

`ifdef IO_STALL_EN
  logic r_io_last;
  // The full flag lags one cycle, so the byte after an IO write is checked as well.
  assign w_stall = io_buffer_full & (is_io(r_addr) | r_io_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_io_last <= 1'b0;
    end else if (rdy) begin
      r_io_last <= mem_wr & is_io(r_addr);
    end
  end
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full;
  assign w_stall     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_rd_last   = 1'b0;
    w_wr_last   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_if) begin
          w_state_nxt = ST_READ;
        end else if (w_gnt_lsb) begin
          w_state_nxt = lsb_wr ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        w_issue = (r_cnt < r_n);
        if (rollback_from_rob) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == r_n) begin
          w_rd_last   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        w_issue = ~w_stall;
        if (!w_stall && (r_cnt == r_n - 3'd1)) begin
          w_wr_last   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte r_cnt-1 arrives on mem_din one cycle after its address was driven.
  always_comb begin
    w_asm = r_buf;
    case (r_cnt)
      3'd1:    w_asm[7:0]   = mem_din;
      3'd2:    w_asm[15:8]  = mem_din;
      3'd3:    w_asm[23:16] = mem_din;
      3'd4:    w_asm[31:24] = mem_din;
      default: ;
    endcase
  end

  always_comb begin
    case (r_size)
      SIZE_B:  w_ext = {{(DATA_W-8){r_signed & w_asm[7]}}, w_asm[7:0]};
      SIZE_H:  w_ext = {{(DATA_W-16){r_signed & w_asm[15]}}, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_n         <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_is_if     <= 1'b0;
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_data   <= '0;
      r_lsb_rdata <= '0;
    end else if (rdy) begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_gnt_if || w_gnt_lsb) begin
            r_is_if  <= w_gnt_if;
            r_addr   <= w_gnt_if ? if_addr : lsb_addr;
            r_n      <= w_gnt_if ? 3'd4 : size_bytes(lsb_size);
            r_size   <= lsb_size;
            r_signed <= lsb_signed;
            r_wdata  <= lsb_wdata;
            r_cnt    <= '0;
            r_buf    <= '0;
          end
        end
        ST_READ: begin
          if (!rollback_from_rob) begin
            if (r_cnt != 3'd0) r_buf <= w_asm;
            if (w_issue) begin
              r_addr <= r_addr + ADDR_W'(1);
              r_cnt  <= r_cnt + 3'd1;
            end
            if (w_rd_last) begin
              if (r_is_if) begin
                r_if_done <= 1'b1;
                r_if_data <= w_asm;
              end else begin
                r_lsb_done  <= 1'b1;
                r_lsb_rdata <= w_ext;
              end
            end
          end
        end
        ST_WRITE: begin
          if (w_issue) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_cnt   <= r_cnt + 3'd1;
            r_wdata <= r_wdata >> 8;
            if (w_wr_last) r_lsb_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_bus_act = (r_state == ST_WRITE) | ((r_state == ST_READ) & (r_cnt < r_n));
  assign mem_a     = w_bus_act ? r_addr : '0;
  assign mem_dout  = (r_state == ST_WRITE) ? r_wdata[7:0] : 8'd0;
  assign mem_wr    = (r_state == ST_WRITE) & rdy & ~w_stall;

  assign if_done   = r_if_done;
  assign if_data   = r_if_data;
  assign lsb_done  = r_lsb_done;
  assign lsb_rdata = r_lsb_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: expected writes, read addresses and done events are queued
// by the stimulus tasks and checked by an independent negedge monitor.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback_from_rob;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_valid;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic        lsb_signed;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int total = 0;
  int bad   = 0;
  int if_done_cnt = 0;
  logic [15:0] cyc = 16'd0;

  logic [47:0] exp_if_q[$];   // {cycle, if_data}
  logic [48:0] exp_lsb_q[$];  // {is_load, cycle, lsb_rdata}
  logic [55:0] exp_wr_q[$];   // {cycle, mem_a, mem_dout}
  logic [47:0] exp_bus_q[$];  // {cycle, mem_a} with mem_wr=0
  logic [47:0] e_if, e_bus;
  logic [48:0] e_lsb;
  logic [55:0] e_wr;

  logic [7:0] ram [0:65535];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_from_rob(rollback_from_rob),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_signed(lsb_signed),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // clock / reset / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;
  always @(posedge clk) mem_din <= ram[mem_a[15:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (if_done) begin
        if_done_cnt++;
        if (exp_if_q.size() == 0) check("if_done_expected", 64'(exp_if_q.size()), 64'd1);
        else begin
          e_if = exp_if_q.pop_front();
          check("if_done", {16'(0), cyc, if_data}, {16'(0), e_if});
        end
      end
      if (lsb_done) begin
        if (exp_lsb_q.size() == 0) check("lsb_done_expected", 64'(exp_lsb_q.size()), 64'd1);
        else begin
          e_lsb = exp_lsb_q.pop_front();
          if (e_lsb[48]) check("lsb_load", {16'(0), cyc, lsb_rdata}, {16'(0), e_lsb[47:0]});
          else check("lsb_store_done_cycle", 64'(cyc), 64'(e_lsb[47:32]));
        end
      end
      if (mem_wr) begin
        if (exp_wr_q.size() == 0) check("mem_write_expected", 64'(exp_wr_q.size()), 64'd1);
        else begin
          e_wr = exp_wr_q.pop_front();
          check("mem_write", {8'(0), cyc, mem_a, mem_dout}, {8'(0), e_wr});
        end
      end
      if (!mem_wr && rdy && mem_a != 32'd0) begin
        if (exp_bus_q.size() == 0) check("mem_addr_expected", 64'(exp_bus_q.size()), 64'd1);
        else begin
          e_bus = exp_bus_q.pop_front();
          check("mem_read_addr", {16'(0), cyc, mem_a}, {16'(0), e_bus});
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 0;
    while ((if_valid || lsb_valid) && budget < 60) begin
      tick();
      budget++;
      if (if_done)  if_valid  = 1'b0;
      if (lsb_done) lsb_valid = 1'b0;
    end
    check("drain_in_time", {63'd0, if_valid | lsb_valid}, 64'd0);
    if_valid  = 1'b0;
    lsb_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic push_reads(input logic [15:0] g, input logic [31:0] addr, input int n);
    for (int k = 0; k < n; k++)
      if (addr + 32'(k) != 32'd0) exp_bus_q.push_back({g + 16'(k), addr + 32'(k)});
  endtask

  task automatic set_lsb_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                              input int n, input logic [31:0] exp, input logic [15:0] g);
    lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_size = size; lsb_signed = sgn; lsb_addr = addr;
    push_reads(g, addr, n);
    exp_lsb_q.push_back({1'b1, g + 16'(n + 1), exp});
  endtask

  task automatic set_if(input logic [31:0] addr, input logic [31:0] exp, input logic [15:0] g);
    if_valid = 1'b1; if_addr = addr;
    push_reads(g, addr, 4);
    exp_if_q.push_back({g + 16'd5, exp});
  endtask

  task automatic set_store(input logic [31:0] addr, input logic [1:0] size, input int n,
                           input logic [31:0] data, input logic [15:0] g, input int done_dly);
    lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_size = size; lsb_signed = 1'b0;
    lsb_addr = addr; lsb_wdata = data;
    exp_lsb_q.push_back({1'b0, g + 16'(n + done_dly), 32'd0});
  endtask

  task automatic push_wr(input logic [15:0] c, input logic [31:0] a, input logic [7:0] d);
    exp_wr_q.push_back({c, a, d});
  endtask

  task automatic lsb_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input int n, input logic [31:0] exp);
    set_lsb_load(addr, size, sgn, n, exp, cyc + 16'd1);
    drain();
  endtask

  task automatic tie_test();
    logic [15:0] g;
    g = cyc + 16'd1;
    set_lsb_load(32'h2010, 2'b00, 1'b1, 1, 32'hFFFF_FF80, g);
    set_if(32'h1000, 32'h0010_0513, g + 16'd3);
    drain();
  endtask

  logic [15:0] g;
  int saved;

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback_from_rob = 1'b0;
    if_valid = 1'b0; if_addr = '0; lsb_valid = 1'b0; lsb_wr = 1'b0; lsb_size = '0;
    lsb_signed = 1'b0; lsb_addr = '0; lsb_wdata = '0; io_buffer_full = 1'b0; mem_din = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
    ram[16'h2002] = 8'hFE; ram[16'h2003] = 8'hFF; ram[16'h2010] = 8'h80;
    ram[16'h2020] = 8'h11; ram[16'h2021] = 8'h22; ram[16'h2022] = 8'h33; ram[16'h2023] = 8'h84;
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'h34; ram[16'h0000] = 8'h12; ram[16'h0001] = 8'h77;

    tick(); tick();
    check("reset_bus", {23'd0, mem_wr, mem_a, mem_dout}, 64'd0);
    check("reset_done", {62'd0, if_done, lsb_done}, 64'd0);
    check("reset_if_data", 64'(if_data), 64'd0);
    check("reset_lsb_rdata", 64'(lsb_rdata), 64'd0);
    rst = 1'b0;
    tick();

    // first tie after reset goes to LSB, IF follows back-to-back; next tie again LSB
    tie_test();
    tie_test();

    lsb_load(32'h2002, 2'b01, 1'b1, 2, 32'hFFFF_FFFE);
    lsb_load(32'h2002, 2'b01, 1'b0, 2, 32'h0000_FFFE);
    lsb_load(32'h2010, 2'b00, 1'b0, 1, 32'h0000_0080);
    lsb_load(32'h2020, 2'b10, 1'b1, 4, 32'h8433_2211);
    lsb_load(32'hFFFF_FFFF, 2'b01, 1'b0, 2, 32'h0000_1234);
    set_if(32'hFFFF_FFFE, 32'h7712_34AA, cyc + 16'd1);
    drain();

    // word store with a rollback in its second byte cycle still completes
    g = cyc + 16'd1;
    set_store(32'h3000, 2'b10, 4, 32'hDEAD_BEEF, g, 0);
    push_wr(g, 32'h3000, 8'hEF); push_wr(g + 16'd1, 32'h3001, 8'hBE);
    push_wr(g + 16'd2, 32'h3002, 8'hAD); push_wr(g + 16'd3, 32'h3003, 8'hDE);
    tick(); tick();
    rollback_from_rob = 1'b1;
    tick();
    rollback_from_rob = 1'b0;
    drain();

    // rdy low for two cycles in the middle of a half store
    g = cyc + 16'd1;
    set_store(32'h4000, 2'b01, 2, 32'h0000_A55A, g, 2);
    push_wr(g, 32'h4000, 8'h5A); push_wr(g + 16'd3, 32'h4001, 8'hA5);
    tick(); tick();
    rdy = 1'b0;
    tick(); tick();
    rdy = 1'b1;
    drain();

    // rollback in A0+1 of an IF fetch aborts it
    g = cyc + 16'd1;
    if_valid = 1'b1; if_addr = 32'h1000;
    push_reads(g, 32'h1000, 2);
    saved = if_done_cnt;
    tick(); tick();
    rollback_from_rob = 1'b1; if_valid = 1'b0;
    tick();
    rollback_from_rob = 1'b0;
    check("rollback_idle_bus", {31'd0, mem_wr, mem_a}, 64'd0);
    repeat (8) tick();
    check("rollback_no_if_done", 64'(if_done_cnt), 64'(saved));

    // byte store to IO space while the UART buffer reports full
    g = cyc + 16'd1;
`ifdef IO_STALL_EN
    set_store(32'h0003_0000, 2'b00, 1, 32'h0000_0055, g, 3);
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) exp_bus_q.push_back({g + 16'(k), 32'h0003_0000});
    push_wr(g + 16'd3, 32'h0003_0000, 8'h55);
    tick(); tick(); tick(); tick();
    io_buffer_full = 1'b0;
    drain();
`else
    set_store(32'h0003_0000, 2'b00, 1, 32'h0000_0055, g, 0);
    io_buffer_full = 1'b1;
    push_wr(g, 32'h0003_0000, 8'h55);
    drain();
    io_buffer_full = 1'b0;
`endif

    // asynchronous reset in the middle of a word store
    g = cyc + 16'd1;
    lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h5000;
    lsb_wdata = 32'h0403_0201;
    push_wr(g, 32'h5000, 8'h01); push_wr(g + 16'd1, 32'h5001, 8'h02);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("async_reset_bus", {31'd0, mem_wr, mem_a}, 64'd0);
    lsb_valid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("async_reset_no_done", {63'd0, lsb_done}, 64'd0);

    check("queues_empty", 64'(exp_if_q.size() + exp_lsb_q.size() + exp_wr_q.size()
                               + exp_bus_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
